// File: rtl/amo_pkg.sv
// Shared AMO definitions: opcode encoding (matches the external AMO ALU),
// sequencer states and the opcode legality check.
package amo_pkg;

    localparam logic [4:0] INST_AMO_ADD  = 5'h00;
    localparam logic [4:0] INST_AMO_SWAP = 5'h01;
    localparam logic [4:0] INST_AMO_XOR  = 5'h04;
    localparam logic [4:0] INST_AMO_OR   = 5'h08;
    localparam logic [4:0] INST_AMO_AND  = 5'h0C;
    localparam logic [4:0] INST_AMO_MIN  = 5'h10;
    localparam logic [4:0] INST_AMO_MAX  = 5'h14;
    localparam logic [4:0] INST_AMO_MINU = 5'h18;
    localparam logic [4:0] INST_AMO_MAXU = 5'h1C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_RSP
    } amo_state_e;

    function automatic logic is_legal_amo(input logic [4:0] op);
        logic legal;
        case (op)
            INST_AMO_ADD, INST_AMO_SWAP, INST_AMO_XOR, INST_AMO_OR, INST_AMO_AND,
            INST_AMO_MIN, INST_AMO_MAX, INST_AMO_MINU, INST_AMO_MAXU: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/amo_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after rr_ptr
// and moves the pointer past the winner when the grant is taken.
module amo_rr_arbiter #(
    parameter int NUM_REQS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQS-1:0]         req_valid,
    input  logic                        advance,
    output logic                        grant_valid,
    output logic [NUM_REQS-1:0]         grant_oh,
    output logic [$clog2(NUM_REQS)-1:0] grant_idx
);

    localparam int IDXW = $clog2(NUM_REQS);

    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] cand;

    // Scan farthest offset first so the nearest valid index at/after rr_ptr wins.
    // NUM_REQS is a power of two, so the IDXW-bit add wraps for free.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            cand = rr_ptr + IDXW'(i);
            if (req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_valid)
            grant_oh[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (advance)
            rr_ptr <= grant_idx + IDXW'(1);
    end

endmodule

// File: rtl/amo_rmw_ctrl.sv
// Atomic read-modify-write sequencer: arbitrates requesters, reads memory,
// runs the shared external AMO ALU, writes the result back, returns old value.
module amo_rmw_ctrl
    import amo_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int ADDRW    = 32,
    parameter int DATAW    = 32,
    parameter int TAGW     = 8
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [NUM_REQS-1:0]         req_valid,
    output logic [NUM_REQS-1:0]         req_ready,
    input  logic [NUM_REQS*5-1:0]       req_op,
    input  logic [NUM_REQS*ADDRW-1:0]   req_addr,
    input  logic [NUM_REQS*DATAW-1:0]   req_data,
    input  logic [NUM_REQS*TAGW-1:0]    req_tag,

    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_req_rw,
    output logic [ADDRW-1:0]            mem_req_addr,
    output logic [DATAW-1:0]            mem_req_data,
    input  logic                        mem_rsp_valid,
    input  logic [DATAW-1:0]            mem_rsp_data,

    output logic [4:0]                  alu_op,
    output logic [DATAW-1:0]            alu_in1,
    output logic [DATAW-1:0]            alu_in2,
    input  logic [DATAW-1:0]            alu_result,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATAW-1:0]            rsp_data,
    output logic [TAGW-1:0]             rsp_tag,
    output logic [$clog2(NUM_REQS)-1:0] rsp_idx,
    output logic                        rsp_err,

    output logic                        busy
);

    localparam int IDXW = $clog2(NUM_REQS);

    amo_state_e state, state_nxt;

    logic                grant_valid;
    logic [NUM_REQS-1:0] grant_oh;
    logic [IDXW-1:0]     grant_idx;
    logic                accept;
    logic                rd_done;
    int                  gsel;

    logic [4:0]          op_q;
    logic [ADDRW-1:0]    addr_q;
    logic [DATAW-1:0]    data_q;
    logic [TAGW-1:0]     tag_q;
    logic [IDXW-1:0]     idx_q;
    logic [DATAW-1:0]    old_q;
    logic [DATAW-1:0]    wdata_q;
    logic                err_q;

    assign accept  = (state == ST_IDLE) && grant_valid;
    assign rd_done = (state == ST_RD_WAIT) && mem_rsp_valid;
    assign gsel    = int'(grant_idx);

    amo_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .advance     (accept),
        .grant_valid (grant_valid),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        rsp_valid     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    req_ready = grant_oh;
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_rsp_valid)
                    state_nxt = is_legal_amo(op_q) ? ST_WR_REQ : ST_RSP;
            end
            ST_WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                if (mem_req_ready)
                    state_nxt = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            old_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= req_op[gsel*5 +: 5];
                addr_q <= req_addr[gsel*ADDRW +: ADDRW];
                data_q <= req_data[gsel*DATAW +: DATAW];
                tag_q  <= req_tag[gsel*TAGW +: TAGW];
                idx_q  <= grant_idx;
                err_q  <= 1'b0;
            end
            if (rd_done) begin
                old_q <= mem_rsp_data;
                if (is_legal_amo(op_q))
                    wdata_q <= alu_result;
                else
                    err_q <= 1'b1;
            end
        end
    end

    // The read data is forwarded to the ALU in the capture cycle so wdata_q can
    // take the result on the same edge that enters WR_REQ; afterwards old_q holds.
    assign alu_op       = op_q;
    assign alu_in1      = rd_done ? mem_rsp_data : old_q;
    assign alu_in2      = data_q;

    assign mem_req_addr = addr_q;
    assign mem_req_data = wdata_q;

    assign rsp_data     = old_q;
    assign rsp_tag      = tag_q;
    assign rsp_idx      = idx_q;
    assign rsp_err      = err_q;

    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_amo_rmw_ctrl.sv
// Scoreboard bench for amo_rmw_ctrl: directed AMO vectors, a memory and ALU
// model around the DUT, and a negedge monitor comparing writes and responses.
module tb_amo_rmw_ctrl;
    import amo_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*5-1:0]    req_op = '0;
    logic [N*32-1:0]   req_addr = '0;
    logic [N*32-1:0]   req_data = '0;
    logic [N*8-1:0]    req_tag = '0;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic              mem_req_rw;
    logic [31:0]       mem_req_addr;
    logic [31:0]       mem_req_data;
    logic              mem_rsp_valid = 1'b0;
    logic [31:0]       mem_rsp_data = '0;
    logic [4:0]        alu_op;
    logic [31:0]       alu_in1, alu_in2, alu_result;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_data;
    logic [7:0]        rsp_tag;
    logic [1:0]        rsp_idx;
    logic              rsp_err;
    logic              busy;

    amo_rmw_ctrl #(.NUM_REQS(N), .ADDRW(32), .DATAW(32), .TAGW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_idx(rsp_idx), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // External AMO ALU
    always_comb begin
        case (alu_op)
            INST_AMO_ADD:  alu_result = alu_in1 + alu_in2;
            INST_AMO_SWAP: alu_result = alu_in2;
            INST_AMO_XOR:  alu_result = alu_in1 ^ alu_in2;
            INST_AMO_OR:   alu_result = alu_in1 | alu_in2;
            INST_AMO_AND:  alu_result = alu_in1 & alu_in2;
            INST_AMO_MIN:  alu_result = ($signed(alu_in1) < $signed(alu_in2)) ? alu_in1 : alu_in2;
            INST_AMO_MAX:  alu_result = ($signed(alu_in1) > $signed(alu_in2)) ? alu_in1 : alu_in2;
            INST_AMO_MINU: alu_result = (alu_in1 < alu_in2) ? alu_in1 : alu_in2;
            INST_AMO_MAXU: alu_result = (alu_in1 > alu_in2) ? alu_in1 : alu_in2;
            default:       alu_result = alu_in1;
        endcase
    end

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        logic [1:0]  idx;
        logic        err;
        int          lat;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    rsp_exp_t    rsp_q[$];
    wr_exp_t     wr_q[$];
    logic [31:0] mem [logic [31:0]];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0;
    int rd_stall = 0, wr_stall = 0, rsp_stall = 0;
    int rem[N] = '{0, 0, 0, 0};
    logic [N-1:0] acc_mask = '0;
    bit suppress_rsp = 0, inject_rsp = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory, response sink and scoreboard monitor, all sampled at negedge.
    initial begin
        bit          pend = 0, mem_held = 0, rsp_held = 0;
        logic [31:0] pend_data = '0;
        logic [64:0] mem_prev = '0;
        logic [42:0] rsp_prev = '0;
        rsp_exp_t    er;
        wr_exp_t     ew;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) pend = 0;

            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            if (pend) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = pend_data;
                pend = 0;
            end else if (inject_rsp) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEADBEEF;
                inject_rsp = 0;
            end

            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (mem_req_rw && wr_stall > 0) wr_stall--;
                else if (!mem_req_rw && rd_stall > 0) rd_stall--;
                else mem_req_ready = 1'b1;
            end
            if (mem_held) chk("mem_req_stable", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data}, {1'b1, mem_prev});
            mem_held = mem_req_valid && !mem_req_ready;
            mem_prev = {mem_req_rw, mem_req_addr, mem_req_data};
            if (mem_req_valid && mem_req_ready) begin
                if (!mem_req_rw) begin
                    rd_cnt++;
                    if (!suppress_rsp) begin
                        pend = 1;
                        pend_data = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 32'h0;
                    end
                end else begin
                    wr_cnt++;
                    mem[mem_req_addr] = mem_req_data;
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", {mem_req_addr, mem_req_data}, 96'h0);
                    end else begin
                        ew = wr_q.pop_front();
                        chk("wr_addr", mem_req_addr, ew.addr);
                        chk("wr_data", mem_req_data, ew.data);
                    end
                end
            end

            rsp_ready = 1'b1;
            if (rsp_valid && rsp_stall > 0) begin
                rsp_ready = 1'b0;
                rsp_stall--;
            end
            if (rsp_held) chk("rsp_stable", {rsp_valid, rsp_data, rsp_tag, rsp_idx, rsp_err}, {1'b1, rsp_prev});
            rsp_held = rsp_valid && !rsp_ready;
            rsp_prev = {rsp_data, rsp_tag, rsp_idx, rsp_err};
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {rsp_data, rsp_tag}, 96'h0);
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_data", rsp_data, er.data);
                    chk("rsp_tag", rsp_tag, er.tag);
                    chk("rsp_idx", rsp_idx, er.idx);
                    chk("rsp_err", rsp_err, er.err);
                    if (er.lat >= 0) chk("rsp_latency", cyc - acc_cyc, er.lat);
                end
            end

            if (req_ready != '0) begin
                chk("req_ready_onehot", $onehot(req_ready), 1);
                acc_mask = acc_mask | req_ready;
                acc_cyc  = cyc;
            end
        end
    end

    // Requesters: hold a request until it is granted; rem[i] ops remain.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) begin
                    acc_mask[i] = 1'b0;
                    if (rem[i] > 0) rem[i]--;
                end
                req_valid[i] = (rem[i] > 0);
            end
        end
    end

    task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [7:0] tag, input int n);
        req_op[i*5 +: 5]    = op;
        req_addr[i*32 +: 32] = addr;
        req_data[i*32 +: 32] = data;
        req_tag[i*8 +: 8]    = tag;
        rem[i] = n;
    endtask

    task automatic exp_rsp(input logic [31:0] d, input logic [7:0] t, input logic [1:0] ix,
                           input logic e, input int lat);
        rsp_exp_t r;
        r.data = d; r.tag = t; r.idx = ix; r.err = e; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wr_exp_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            #1;
            done = (rsp_q.size() == 0) && (req_valid == '0) && !busy &&
                   (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) && (rem[3] == 0);
        end
        chk(name, done, 1);
    endtask

    initial begin
        int wr0, rd0, rs0;
        bit seen;

        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_mem_req_valid", mem_req_valid, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_alu", {alu_op, alu_in1, alu_in2}, 0);
        chk("reset_mem_req", {mem_req_rw, mem_req_addr, mem_req_data}, 0);
        chk("reset_rsp_fields", {rsp_data, rsp_tag, rsp_idx, rsp_err}, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Round robin from rr_ptr 0, all four valid, req0 has two ops
        mem[32'h200] = 32'd10;
        mem[32'h210] = 32'h11;
        mem[32'h220] = 32'hF0;
        mem[32'h230] = 32'h0F;
        exp_rsp(32'd10, 8'h10, 2'd0, 0, -1);  exp_wr(32'h200, 32'd11);
        exp_rsp(32'h11, 8'h11, 2'd1, 0, -1);  exp_wr(32'h210, 32'h77);
        exp_rsp(32'hF0, 8'h12, 2'd2, 0, -1);  exp_wr(32'h220, 32'h0F);
        exp_rsp(32'h0F, 8'h13, 2'd3, 0, -1);  exp_wr(32'h230, 32'hFF);
        exp_rsp(32'd11, 8'h10, 2'd0, 0, -1);  exp_wr(32'h200, 32'd12);
        @(posedge clk); #1;
        set_req(0, INST_AMO_ADD,  32'h200, 32'd1,  8'h10, 2);
        set_req(1, INST_AMO_SWAP, 32'h210, 32'h77, 8'h11, 1);
        set_req(2, INST_AMO_XOR,  32'h220, 32'hFF, 8'h12, 1);
        set_req(3, INST_AMO_OR,   32'h230, 32'hF0, 8'h13, 1);
        drain("drain_rr");

        // MAXU on req3 alone; moves rr_ptr back to 0
        mem[32'h300] = 32'hFFFFFFFF;
        exp_rsp(32'hFFFFFFFF, 8'h33, 2'd3, 0, -1);  exp_wr(32'h300, 32'hFFFFFFFF);
        @(posedge clk); #1;
        set_req(3, INST_AMO_MAXU, 32'h300, 32'd5, 8'h33, 1);
        drain("drain_maxu");

        // req1 absent: grant order 0,2,3,0
        mem[32'h240] = 32'hFF;
        mem[32'h250] = 32'h7;
        mem[32'h260] = 32'h80000000;
        exp_rsp(32'hFF,       8'h40, 2'd0, 0, -1);  exp_wr(32'h240, 32'h0F);
        exp_rsp(32'h7,        8'h42, 2'd2, 0, -1);  exp_wr(32'h250, 32'h7);
        exp_rsp(32'h80000000, 8'h43, 2'd3, 0, -1);  exp_wr(32'h260, 32'h2);
        exp_rsp(32'h0F,       8'h40, 2'd0, 0, -1);  exp_wr(32'h240, 32'h0F);
        @(posedge clk); #1;
        set_req(0, INST_AMO_AND,  32'h240, 32'h0F,       8'h40, 2);
        set_req(2, INST_AMO_MAX,  32'h250, 32'hFFFFFFFF, 8'h42, 1);
        set_req(3, INST_AMO_MINU, 32'h260, 32'h2,        8'h43, 1);
        drain("drain_drop1");

        // ADD with zero-wait memory: rsp_valid in the 5th cycle counting accept
        mem[32'h100] = 32'h0000000A;
        exp_rsp(32'hA, 8'h5A, 2'd0, 0, 4);  exp_wr(32'h100, 32'h0000000F);
        @(posedge clk); #1;
        set_req(0, INST_AMO_ADD, 32'h100, 32'd5, 8'h5A, 1);
        drain("drain_add");

        // Signed MIN
        mem[32'h110] = 32'h3;
        exp_rsp(32'h3, 8'h21, 2'd1, 0, 4);  exp_wr(32'h110, 32'hFFFFFFFE);
        @(posedge clk); #1;
        set_req(1, INST_AMO_MIN, 32'h110, 32'hFFFFFFFE, 8'h21, 1);
        drain("drain_min");

        // Backpressure on both memory phases and on the response
        wr0 = wr_cnt; rd0 = rd_cnt;
        mem[32'h400] = 32'h20;
        exp_rsp(32'h20, 8'h77, 2'd2, 0, -1);  exp_wr(32'h400, 32'h30);
        rd_stall = 4; wr_stall = 3; rsp_stall = 2;
        @(posedge clk); #1;
        set_req(2, INST_AMO_ADD, 32'h400, 32'h10, 8'h77, 1);
        drain("drain_stall");
        chk("stall_reads", rd_cnt - rd0, 1);
        chk("stall_writes", wr_cnt - wr0, 1);

        // Illegal opcode: no write, err flagged, old value returned
        wr0 = wr_cnt;
        mem[32'h500] = 32'h1234;
        exp_rsp(32'h1234, 8'hEE, 2'd0, 1, -1);
        @(posedge clk); #1;
        set_req(0, 5'h1F, 32'h500, 32'h99, 8'hEE, 1);
        drain("drain_illegal");
        chk("illegal_no_write", wr_cnt - wr0, 0);

        // Reset while waiting for read data; late response must be dropped
        wr0 = wr_cnt; rd0 = rd_cnt; rs0 = rsp_cnt;
        suppress_rsp = 1;
        mem[32'h600] = 32'h50;
        @(posedge clk); #1;
        set_req(1, INST_AMO_ADD, 32'h600, 32'h1, 8'h66, 1);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = (rd_cnt != rd0);
        end
        chk("reset_test_read_issued", seen, 1);
        @(posedge clk); #1;
        chk("busy_in_rd_wait", busy, 1);
        reset = 1'b0;
        #1;
        chk("busy_async_reset", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        suppress_rsp = 0;
        inject_rsp = 1;
        repeat (10) @(negedge clk);
        #1;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_no_write", wr_cnt - wr0, 0);
        chk("post_reset_no_rsp", rsp_cnt - rs0, 0);
        chk("post_reset_mem_idle", mem_req_valid, 0);

        chk("rsp_queue_empty", rsp_q.size(), 0);
        chk("wr_queue_empty", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/amo_rmw_ctrl.md
Name: amo_rmw_ctrl

Overview:
- Read-modify-write sequencer that shares one combinational AMO ALU among NUM_REQS requesters (per-lane atomic issue).
- Arbitrates requests round-robin and serialises them: memory read, feed old value and operand to the ALU, memory write of the ALU result, then return the old value to the requester.
- Sits between the LSU atomic path and the memory request/response port. The ALU is instantiated outside this block, alongside it.

Parameters:
- NUM_REQS, 4, number of requesters; power of two, at least 2
- ADDRW, 32, address width
- DATAW, 32, data width; must match the ALU
- TAGW, 8, requester tag width, returned unchanged

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQS  per-requester request valid
- req_ready  out  NUM_REQS  per-requester accept; at most one bit high
- req_op  in  NUM_REQS*5  AMO opcode per requester
- req_addr  in  NUM_REQS*ADDRW  word address per requester
- req_data  in  NUM_REQS*DATAW  rs2 operand per requester
- req_tag  in  NUM_REQS*TAGW  tag per requester
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accept
- mem_req_rw  out  1  0 = read, 1 = write
- mem_req_addr  out  ADDRW  latched address
- mem_req_data  out  DATAW  write data (latched ALU result)
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  DATAW  read data
- alu_op  out  5  to ALU
- alu_in1  out  DATAW  to ALU; carries the old memory value
- alu_in2  out  DATAW  to ALU; carries the latched req_data
- alu_result  in  DATAW  from ALU, combinational
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  DATAW  old memory value
- rsp_tag  out  TAGW  latched tag
- rsp_idx  out  log2(NUM_REQS)  winning requester index
- rsp_err  out  1  illegal opcode flag
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (reset low, asynchronous): state IDLE, rr_ptr 0, every output and latch 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RSP.
- IDLE
  - If any req_valid is set, grant the first valid index at or after rr_ptr, wrapping modulo NUM_REQS.
  - Assert req_ready for that index only, combinationally, in that cycle.
  - Latch op, addr, data, tag and idx; set rr_ptr to winner+1, wrapping.
  - Go to RD_REQ.
  - req_ready is 0 in every other state.
- RD_REQ: mem_req_valid=1, rw=0, addr latched. Hold until mem_req_ready, then go to RD_WAIT.
- RD_WAIT
  - On mem_rsp_valid, latch old=mem_rsp_data.
  - Legal op: go to WR_REQ. Illegal op (not ADD/SWAP/XOR/OR/AND/MIN/MAX/MINU/MAXU): go to RSP with err=1 and no write.
  - mem_rsp_valid in any other state is ignored.
- ALU inputs
  - alu_op = latched op; alu_in1 = old; alu_in2 = latched data.
  - All three are stable from the cycle after RD_WAIT exits until RSP exits.
  - wdata latches alu_result on entry to WR_REQ.
- WR_REQ: mem_req_valid=1, rw=1, data=wdata. Hold until mem_req_ready, then go to RSP. No write acknowledgement is awaited.
- RSP: rsp_valid=1, rsp_data=old, tag, idx, err. Hold until rsp_ready, then go to IDLE.
- Latency: with memory ready immediately and read data one cycle after acceptance, the sequence from accept (IDLE) to the rsp_valid cycle is 5 cycles. Back-to-back throughput is one op per 5 cycles.
- Request-side stability: mem_req_* must not change while valid and not ready.
- Requester-side stability: a requester must hold its request until it sees req_ready.
- Same-address ops from different requesters are naturally serialised; no bypass is needed.
- Reset mid-operation aborts the op with no response. A memory response arriving after reset is dropped, since the block is in IDLE.

Decomposition:
- Shared package amo_pkg:
  - 5-bit AMO opcode constants, the same INST_AMO_* encoding the ALU uses
  - state enum
  - function is_legal_amo(op)
- One sub-module: amo_rr_arbiter, holding the NUM_REQS round-robin pointer and the one-hot grant plus index.

Test Plan:
- AMO_ADD, req0, addr 0x100, data 5, mem returns 0x0000000A → write 0x0000000F to 0x100; rsp_data 0xA, tag echoed; rsp_valid 5 cycles after accept with zero-wait memory.
- req0..req3 valid continuously, rr_ptr 0 → grant order 0,1,2,3,0; with req1 dropped, order becomes 0,2,3,0.
- AMO_MIN, mem 0x00000003, data 0xFFFFFFFE → write 0xFFFFFFFE, rsp 3. AMO_MAXU, mem 0xFFFFFFFF, data 5 → write 0xFFFFFFFF.
- mem_req_ready low 4 cycles in RD_REQ and 3 cycles in WR_REQ; rsp_ready low 2 cycles → mem_req_* and rsp_* are held stable; exactly one read and one write are issued.
- Illegal op 0x1F, mem 0x1234 → no write request; rsp_err=1, rsp_data 0x1234.
- reset low during RD_WAIT, then mem_rsp_valid pulses after release → block stays in IDLE, busy=0, no write, no response.
